// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one 1-bit slice processes the operands LSB first, one bit per clock,
// and the result and flags are published together on entry to DONE.
module serial_alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, result_q, result_d;
  logic [2:0]       sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;

  logic             invert, bit_a, bit_b, sum, carry_nx, slice_bit, last, less;
  logic [WIDTH-1:0] final_res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sr_q     <= '0;
      result_q <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sr_q     <= sr_d;
      result_q <= result_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  // The single bit slice, fed by the current bit of the captured operands
  always_comb begin
    invert   = (sel_q == OP_SUB) || (sel_q == OP_SLT);
    bit_a    = a_q[cnt_q];
    bit_b    = b_q[cnt_q] ^ invert;
    sum      = bit_a ^ bit_b ^ carry_q;
    carry_nx = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
    case (sel_q)
      OP_XOR:  slice_bit = bit_a ^ bit_b;
      OP_AND:  slice_bit = bit_a & bit_b;
      OP_NAND: slice_bit = ~(bit_a & bit_b);
      OP_NOR:  slice_bit = ~(bit_a | bit_b);
      OP_OR:   slice_bit = bit_a | bit_b;
      default: slice_bit = sum;
    endcase
    last      = (cnt_q == CW'(WIDTH - 1));
    final_res = {slice_bit, sr_q[WIDTH-1:1]};
    // On the MSB, carry_q is the carry into it and carry_nx the carry out
    less      = sum ^ (carry_q ^ carry_nx);
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sr_d     = sr_q;
    result_d = result_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sel_d   = sel;
          cnt_d   = '0;
          carry_d = (sel == OP_SUB) || (sel == OP_SLT);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sr_d    = final_res;
        carry_d = carry_nx;
        if (last) begin
          state_d = S_DONE;
          if (sel_q == OP_SLT) begin
            result_d = WIDTH'(less);
            zero_d   = ~less;
          end else begin
            result_d = final_res;
            zero_d   = (final_res == '0);
          end
          if ((sel_q == OP_ADD) || (sel_q == OP_SUB)) begin
            cout_d = carry_nx;
            ovf_d  = carry_q ^ carry_nx;
          end else begin
            cout_d = 1'b0;
            ovf_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carryout = cout_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule
